// File: rtl/corevx_avalon_mem.sv
// Avalon-MM burst memory responder: read latency, bypass-bit aliasing, error window, backdoor read.
// Optional random stall insertion is enabled by defining COREVX_MEM_RANDOM_STALL_EN.
module corevx_avalon_mem #(
  parameter int ADDR_WIDTH   = 34,
  parameter int DEPTH_WORDS  = 131072,
  parameter int BURST_WIDTH  = 5,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS_BIT   = 31,
  parameter int ERR_BASE     = 0,
  parameter int ERR_LIMIT    = 0,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  m_address,
  input  logic [BURST_WIDTH-1:0] m_burstcount,
  input  logic                   m_read,
  input  logic                   m_write,
  input  logic [31:0]            m_writedata,
  input  logic [3:0]             m_byteenable,
  output logic                   m_waitrequest,
  output logic [31:0]            m_readdata,
  output logic                   m_readdatavalid,
  output logic [1:0]             m_response,
  input  logic [IDX_W-1:0]       bd_index,
  output logic [31:0]            bd_rdata
);
  localparam int HI_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [HI_W-1:0] HI_KEEP = ~(HI_W'(1) << (BYPASS_BIT - IDX_W - 2));
  localparam logic [3:0] LAT_INIT = 4'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [31:0] WIN_SIZE = 32'(ERR_LIMIT - ERR_BASE);

  typedef enum logic [2:0] {ST_IDLE, ST_RD_ACC, ST_RD_LAT, ST_RD_BURST, ST_WR_BURST} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [BURST_WIDTH-1:0] beats_q;
  logic [3:0]             lat_q;
  logic                   hi_err_q;
  logic                   wr_first_q;
  logic [31:0]            mem [DEPTH_WORDS];

  logic [IDX_W-1:0]       cmd_idx, beat_idx;
  logic [BURST_WIDTH-1:0] cmd_beats, beat_cnt;
  logic                   cmd_hi_err, beat_hi_err, beat_err, last_beat;
  logic                   acc_fire, rd_fire, wr_fire;
  logic                   stall_acc, stall_gap;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^m_address[1:0];

`ifdef COREVX_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
  end
  assign stall_acc = lfsr_q[0];
  assign stall_gap = lfsr_q[1];
`else
  assign stall_acc = 1'b0;
  assign stall_gap = 1'b0;
`endif

  // A beat index is an error if it falls in [ERR_BASE, ERR_LIMIT); an empty window never matches.
  function automatic logic in_window(input logic [IDX_W-1:0] idx);
    logic [31:0] off;
    off = 32'(idx) - 32'(ERR_BASE);
    return off < WIN_SIZE;
  endfunction

  // The first write beat is taken straight from the bus; later beats use the latched burst state.
  always_comb begin
    cmd_idx    = m_address[IDX_W+1:2];
    cmd_hi_err = |(m_address[ADDR_WIDTH-1:IDX_W+2] & HI_KEEP);
    cmd_beats  = (m_burstcount == '0) ? BURST_WIDTH'(1) : m_burstcount;
    if (state_q == ST_WR_BURST && wr_first_q) begin
      beat_idx    = cmd_idx;
      beat_hi_err = cmd_hi_err;
      beat_cnt    = cmd_beats;
    end else begin
      beat_idx    = idx_q;
      beat_hi_err = hi_err_q;
      beat_cnt    = beats_q;
    end
    beat_err  = beat_hi_err || in_window(beat_idx);
    last_beat = (beat_cnt == BURST_WIDTH'(1));
    acc_fire  = (state_q == ST_RD_ACC) && !stall_acc;
    rd_fire   = (state_q == ST_RD_BURST) && !stall_gap;
    wr_fire   = (state_q == ST_WR_BURST) && m_write && !stall_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m_read)       state_d = ST_RD_ACC;
        else if (m_write) state_d = ST_WR_BURST;
      end
      ST_RD_ACC:   if (acc_fire) state_d = (READ_LATENCY > 1) ? ST_RD_LAT : ST_RD_BURST;
      ST_RD_LAT:   if (lat_q == 4'd0) state_d = ST_RD_BURST;
      ST_RD_BURST: if (rd_fire && last_beat) state_d = ST_IDLE;
      ST_WR_BURST: if (wr_fire && last_beat) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Handshake: a command or write beat transfers on a rising edge where m_waitrequest is low;
  // a read beat transfers on every cycle with m_readdatavalid high (no backpressure on reads).
  always_comb begin
    m_waitrequest   = !(acc_fire || wr_fire);
    m_readdatavalid = rd_fire;
    m_readdata      = (rd_fire && !beat_err) ? mem[beat_idx] : 32'h0;
    m_response      = ((rd_fire || wr_fire) && !beat_err) ? 2'b00 : 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      beats_q    <= '0;
      lat_q      <= '0;
      hi_err_q   <= 1'b0;
      wr_first_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: wr_first_q <= 1'b1;
        ST_RD_ACC: begin
          if (acc_fire) begin
            idx_q    <= cmd_idx;
            beats_q  <= cmd_beats;
            hi_err_q <= cmd_hi_err;
            lat_q    <= LAT_INIT;
          end
        end
        ST_RD_LAT: if (lat_q != 4'd0) lat_q <= lat_q - 4'd1;
        ST_RD_BURST: begin
          if (rd_fire) begin
            idx_q   <= idx_q + IDX_W'(1);
            beats_q <= beats_q - BURST_WIDTH'(1);
          end
        end
        ST_WR_BURST: begin
          if (wr_fire) begin
            idx_q      <= beat_idx + IDX_W'(1);
            beats_q    <= beat_cnt - BURST_WIDTH'(1);
            hi_err_q   <= beat_hi_err;
            wr_first_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_fire && !beat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (m_byteenable[b]) mem[beat_idx][8*b +: 8] <= m_writedata[8*b +: 8];
      end
    end
  end

  assign bd_rdata = mem[bd_index];

endmodule

// File: doc/corevx_avalon_mem.md
# corevx_avalon_mem

Parametrised Avalon-MM memory responder that sits on the cache's memory-side master port (`m_*`) in cache, PTW and core-level benches. It supports bursts, configurable read latency, bypass-bit address aliasing and a programmable error window. It also has a backdoor read port so checkers can inspect contents without bus traffic. It supersedes the single-word inline memory models in existing benches.

## Interface
Parameters:
- ADDR_WIDTH, 34: width of `m_address`.
- DEPTH_WORDS, 131072: memory depth in 32-bit words; power of two.
- BURST_WIDTH, 5: width of `m_burstcount`.
- READ_LATENCY, 1: cycles from command acceptance to first read beat; range 1..15.
- BYPASS_BIT, 31: address bit ignored for indexing (cached/bypassed alias).
- ERR_BASE, 0: first word index of the error window.
- ERR_LIMIT, 0: word index one past the error window; ERR_BASE==ERR_LIMIT disables the window.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- m_address  in  ADDR_WIDTH  byte address of the first beat.
- m_burstcount  in  BURST_WIDTH  beats in the burst; 0 is treated as 1.
- m_read  in  1  read request.
- m_write  in  1  write request/beat.
- m_writedata  in  32  write beat data.
- m_byteenable  in  4  byte lanes for a write beat.
- m_waitrequest  out  1  low = command/beat accepted this cycle.
- m_readdata  out  32  read beat data.
- m_readdatavalid  out  1  read beat valid.
- m_response  out  2  00 OKAY, 11 error; valid with readdatavalid, or with an accepted write beat.
- bd_index  in  log2(DEPTH_WORDS)  backdoor word index.
- bd_rdata  out  32  combinational `mem[bd_index]`.

## Operation
- Word index = (m_address with BYPASS_BIT cleared) >> 2, taken modulo DEPTH_WORDS.
- Beat index increments by 1 per beat and wraps from DEPTH_WORDS-1 to 0.
- A beat is an error if its index is in [ERR_BASE, ERR_LIMIT), or if any address bit at or above log2(DEPTH_WORDS)+2 is set (BYPASS_BIT excluded).
- Error read beat: readdata=0, response=11.
- Error write beat: memory unchanged, response=11.
- FSM states:
  - IDLE: waitrequest=1.
    - m_read seen -> RD_ACC.
    - Else m_write seen -> WR_BURST.
    - If both are high, the read wins and the write is ignored.
  - RD_ACC: one cycle, waitrequest=0; latches address and beat count; -> RD_LAT.
  - RD_LAT: counts READ_LATENCY-1 cycles; -> RD_BURST.
  - RD_BURST: one beat per cycle, readdatavalid=1; after the last beat -> IDLE. waitrequest stays high throughout.
  - WR_BURST: each cycle with m_write=1 sets waitrequest=0 and consumes a beat.
    - The first beat latches address and burstcount.
    - Enabled bytes are written at the clock edge.
    - Cycles with m_write=0 are idle gaps (waitrequest=1).
    - After the last beat -> IDLE.
- A read beat returns data written by any earlier accepted write beat, including one written in the preceding cycle.

## Timing
- Reset values: m_waitrequest=1, m_readdatavalid=0, m_readdata=0, m_response=11, FSM=IDLE, counters=0.
- Reset does not alter memory contents. Reset mid-burst abandons the burst; the outputs above hold from the next cycle.
- Read timing:
  - Request first seen high at edge E.
  - Acceptance cycle: waitrequest low in E+1.
  - First readdatavalid in cycle E+1+READ_LATENCY.
  - Beats are back-to-back, burstcount cycles total.
- Write timing: waitrequest low one cycle after m_write is seen in IDLE (first beat). In WR_BURST, waitrequest=!m_write, combinational.
- A new command is sampled only in IDLE; requests during RD_* are held off by waitrequest=1.

## Configuration
- COREVX_MEM_RANDOM_STALL_EN.
- Defined: a 16-bit Galois LFSR (seed 16'hACE1, reloaded at reset) inserts stalls.
  - LFSR bit0=1 holds m_waitrequest high in RD_ACC and WR_BURST.
  - LFSR bit1=1 inserts a gap (readdatavalid=0) between read beats.
  - Ordering and data are unchanged.
- Undefined: fully deterministic timing exactly as in Timing.

## Test plan
- Preload mem[0]=BEAFDEAD; read addr 0x0, burstcount 1 -> one beat BEAFDEAD, response 00, readdatavalid at E+2 with READ_LATENCY=1.
- Write FFCC2211 to 0x80000000 (bypass alias of word 0), byteenable 1111 -> response 00; bd_rdata at index 0 = FFCC2211; cached read of 0x0 returns FFCC2211.
- Write burst of 4 to 0x40, data 1..4, byteenable 0011 on beat 2 -> words 0x10..0x13 = 1, upper-half-unchanged|0002, 3, 4; then read burst 4 returns the same values.
- ERR_BASE=8, ERR_LIMIT=9: read burst 4 from 0x18 -> responses 00,00,11,00; beat 3 data 0; write to 0x20 leaves mem[8] unchanged with response 11.
- READ_LATENCY=5, burst 16 from index DEPTH_WORDS-2 -> first beat at E+6; indices wrap to 0; 16 consecutive valid beats.
- Assert rst_n=0 during beat 3 of an 8-beat read -> next cycle readdatavalid=0, waitrequest=1, response=11; a subsequent read returns correct data.
